// File: rtl/fifo_arb_pkg.sv
// Shared types and default sizing for the FIFO write-port arbiter.
// Latency/backpressure: not applicable (declarations only).
package fifo_arb_pkg;

    localparam int NUM_REQ_DEF   = 4;
    localparam int MAX_BURST_DEF = 4;
    localparam int ID_W          = $clog2(NUM_REQ_DEF);
    localparam int CNT_W         = $clog2(MAX_BURST_DEF + 1);

    typedef enum logic {
        IDLE  = 1'b0,
        BURST = 1'b1
    } arb_state_t;

endpackage

// File: rtl/rr_picker.sv
// Rotating priority encoder: first set request scanning from ptr upward, modulo N.
// Latency: combinational. Backpressure: none.
module rr_picker
    import fifo_arb_pkg::*;
#(
    parameter int N  = NUM_REQ_DEF,
    parameter int IW = ID_W
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic          found,
    output logic [IW-1:0] idx
);

    always_comb begin
        found = 1'b0;
        idx   = '0;
        for (int i = 0; i < N; i++) begin
            if (!found && req[(int'(ptr) + i) % N]) begin
                found = 1'b1;
                idx   = IW'((int'(ptr) + i) % N);
            end
        end
    end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin burst arbiter sharing one FIFO write port among NUM_REQ producers.
// Latency: one idle arbitration cycle per grant, then accept->fifo_wr in the same cycle; fifo_full stalls the owner without releasing the grant.
module fifo_wr_arbiter
    import fifo_arb_pkg::*;
#(
    parameter int NUM_REQ    = NUM_REQ_DEF,
    parameter int DATA_WIDTH = 32,
    parameter int MAX_BURST  = MAX_BURST_DEF
) (
    input  logic                                 clock,
    input  logic                                 reset,
    input  logic [NUM_REQ-1:0]                   req_valid,
    input  logic [NUM_REQ-1:0][DATA_WIDTH-1:0]   req_data,
    input  logic [NUM_REQ-1:0]                   req_last,
    output logic [NUM_REQ-1:0]                   req_ready,
    input  logic                                 fifo_full,
    output logic                                 fifo_wr,
    output logic [DATA_WIDTH-1:0]                fifo_data_in,
    output logic [$clog2(NUM_REQ)-1:0]           grant_id,
    output logic                                 busy
);

    localparam int GW = $clog2(NUM_REQ);
    localparam int BW = $clog2(MAX_BURST + 1);

    arb_state_t            state;
    arb_state_t            state_nxt;
    logic [GW-1:0]         rr_ptr;
    logic [GW-1:0]         pick_idx;
    logic                  pick_found;
    logic [BW-1:0]         beat_cnt;
    logic [DATA_WIDTH-1:0] data_hold;
    logic                  accept;
    logic                  release_burst;

    rr_picker #(
        .N  (NUM_REQ),
        .IW (GW)
    ) u_picker (
        .req   (req_valid),
        .ptr   (rr_ptr),
        .found (pick_found),
        .idx   (pick_idx)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt     = state;
        req_ready     = '0;
        accept        = 1'b0;
        release_burst = 1'b0;
        case (state)
            IDLE: begin
                if (pick_found) begin
                    state_nxt = BURST;
                end
            end
            BURST: begin
                req_ready[grant_id] = ~fifo_full;
                accept              = req_valid[grant_id] & ~fifo_full;
                // A stalled owner with valid still high keeps the grant.
                release_burst = ~req_valid[grant_id]
                              | (accept & (req_last[grant_id] | (beat_cnt == BW'(MAX_BURST - 1))));
                if (release_burst) begin
                    state_nxt = IDLE;
                end
            end
        endcase
    end

    assign fifo_wr      = accept;
    assign fifo_data_in = accept ? req_data[grant_id] : data_hold;
    assign busy         = (state == BURST);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            rr_ptr    <= '0;
            grant_id  <= '0;
            beat_cnt  <= '0;
            data_hold <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (pick_found) begin
                        grant_id <= pick_idx;
                        beat_cnt <= '0;
                    end
                end
                BURST: begin
                    if (accept) begin
                        beat_cnt  <= beat_cnt + 1'b1;
                        data_hold <= req_data[grant_id];
                    end
                    // Departing owner drops to lowest priority.
                    if (release_burst) begin
                        rr_ptr <= (grant_id == GW'(NUM_REQ - 1)) ? '0 : grant_id + 1'b1;
                    end
                end
            endcase
        end
    end

endmodule
